// File: rtl/regfile_snapshot_pkg.sv
// Shared types and helpers for the register-file snapshot queue.
// Holds the capture FSM encoding and pointer sizing.
package regfile_snapshot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snapshot_queue_ctrl.sv
// Circular bank-queue bookkeeping: write/read pointers and fill level.
// Clear and reset both empty the queue; storage is untouched here.
module snapshot_queue_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int PW        = 2,
  parameter int OW        = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [OW-1:0] occupancy,
  output logic          full,
  output logic          empty
);

  logic pop_ok;

  assign full   = (occupancy == OW'(NUM_BANKS));
  assign empty  = (occupancy == '0);
  assign pop_ok = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/regfile_snapshot.sv
// Multi-bank register-file snapshot queue with sequence tags,
// valid/ready readout and a saturating overrun counter.
module regfile_snapshot
  import regfile_snapshot_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int REG_FILE_SIZE = 32,
  parameter int NUM_BANKS     = 4,
  parameter int SEQ_WIDTH     = 8,
  parameter int OVR_WIDTH     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic snap_req,
  output logic snap_ready,
  input  logic [REG_FILE_SIZE-1:0][DATA_WIDTH-1:0] data_in,
  output logic [REG_FILE_SIZE-1:0][DATA_WIDTH-1:0] data_out,
  output logic [SEQ_WIDTH-1:0] snap_seq,
  output logic out_valid,
  input  logic out_ready,
  output logic [$clog2(NUM_BANKS+1)-1:0] occupancy,
  output logic [OVR_WIDTH-1:0] overrun_count
);

  localparam int PW = ptr_w(NUM_BANKS);
  localparam int OW = $clog2(NUM_BANKS + 1);

  state_e state;

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 idle;
  logic [SEQ_WIDTH-1:0] seq_ctr;

  logic [REG_FILE_SIZE-1:0][DATA_WIDTH-1:0] bank [NUM_BANKS];
  logic [SEQ_WIDTH-1:0] seq_mem [NUM_BANKS];

  assign idle       = (state == IDLE);
  assign snap_ready = idle && !full;
  assign out_valid  = !empty;
  assign push       = (state == COMMIT) && !clear;
  assign pop        = out_valid && out_ready;
  assign data_out   = bank[rd_ptr];
  assign snap_seq   = seq_mem[rd_ptr];

  snapshot_queue_ctrl #(
    .NUM_BANKS (NUM_BANKS),
    .PW        (PW),
    .OW        (OW)
  ) u_qctrl (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (snap_req && snap_ready) state <= CAPTURE;
        CAPTURE: state <= COMMIT;
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A cleared capture leaves the target bank as it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank[b]    <= '0;
        seq_mem[b] <= '0;
      end
    end else if (state == CAPTURE && !clear) begin
      bank[wr_ptr]    <= data_in;
      seq_mem[wr_ptr] <= seq_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_ctr <= '0;
    end else if (push) begin
      seq_ctr <= seq_ctr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_count <= '0;
    end else if (idle && !clear && snap_req && full
                 && overrun_count != '1) begin
      overrun_count <= overrun_count + 1'b1;
    end
  end

endmodule
